// File: rtl/pic_pkg.sv
// Shared constants for the 8259A-style PIC command path: sequencer states,
// ICW1/OCW3 bit positions and OCW2 R/SL/EOI command codes.
package pic_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_WAIT_ICW2 = 3'd1;
  localparam state_t ST_WAIT_ICW3 = 3'd2;
  localparam state_t ST_WAIT_ICW4 = 3'd3;
  localparam state_t ST_READY     = 3'd4;

  localparam int ICW1_IC4  = 0;
  localparam int ICW1_SNGL = 1;
  localparam int ICW1_LTIM = 3;
  localparam int ICW1_SEL  = 4;

  localparam int OCW3_RIS  = 0;
  localparam int OCW3_RR   = 1;
  localparam int OCW3_P    = 2;
  localparam int OCW3_SEL  = 3;
  localparam int OCW3_SMM  = 5;
  localparam int OCW3_ESMM = 6;

  // OCW2 D7:D5 = R, SL, EOI
  localparam logic [2:0] OCW2_ROT_CLR    = 3'b000;
  localparam logic [2:0] OCW2_NS_EOI     = 3'b001;
  localparam logic [2:0] OCW2_NOP        = 3'b010;
  localparam logic [2:0] OCW2_SP_EOI     = 3'b011;
  localparam logic [2:0] OCW2_ROT_SET    = 3'b100;
  localparam logic [2:0] OCW2_ROT_NS_EOI = 3'b101;
  localparam logic [2:0] OCW2_SET_PRI    = 3'b110;
  localparam logic [2:0] OCW2_ROT_SP_EOI = 3'b111;

  localparam logic [7:0] IMR_INIT_DEFAULT = 8'h00;

endpackage

// File: rtl/pic_ocw_decode.sv
// Combinational OCW2/OCW3 decode: turns a READY-state A0=0 write into the
// next values of the command pulses and the sticky mode flags.
module pic_ocw_decode
  import pic_pkg::*;
(
  input  logic       cmd_wr,
  input  logic [7:0] din,
  input  logic       rot_en,
  input  logic       smm,
  input  logic       rd_isr,
  input  logic [2:0] lvl,
  output logic       eoi_ns_nxt,
  output logic       eoi_sp_nxt,
  output logic       rot_ns_nxt,
  output logic       set_pri_nxt,
  output logic       poll_nxt,
  output logic       rot_en_nxt,
  output logic       smm_nxt,
  output logic       rd_isr_nxt,
  output logic [2:0] lvl_nxt
);

  logic ocw2_wr;
  logic ocw3_wr;

  assign ocw2_wr = cmd_wr && (din[ICW1_SEL] == 1'b0) && (din[OCW3_SEL] == 1'b0);
  assign ocw3_wr = cmd_wr && (din[ICW1_SEL] == 1'b0) && (din[OCW3_SEL] == 1'b1);

  // Pulses default low; flags and lvl hold unless a command rewrites them.
  always_comb begin
    eoi_ns_nxt  = 1'b0;
    eoi_sp_nxt  = 1'b0;
    rot_ns_nxt  = 1'b0;
    set_pri_nxt = 1'b0;
    poll_nxt    = 1'b0;
    rot_en_nxt  = rot_en;
    smm_nxt     = smm;
    rd_isr_nxt  = rd_isr;
    lvl_nxt     = lvl;

    if (ocw2_wr) begin
      case (din[7:5])
        OCW2_NS_EOI: eoi_ns_nxt = 1'b1;
        OCW2_SP_EOI: begin
          eoi_sp_nxt = 1'b1;
          lvl_nxt    = din[2:0];
        end
        OCW2_ROT_NS_EOI: begin
          eoi_ns_nxt = 1'b1;
          rot_ns_nxt = 1'b1;
        end
        OCW2_ROT_SET: rot_en_nxt = 1'b1;
        OCW2_ROT_CLR: rot_en_nxt = 1'b0;
        OCW2_ROT_SP_EOI: begin
          eoi_sp_nxt = 1'b1;
          rot_ns_nxt = 1'b1;
          lvl_nxt    = din[2:0];
        end
        OCW2_SET_PRI: begin
          set_pri_nxt = 1'b1;
          lvl_nxt     = din[2:0];
        end
        default: ;
      endcase
    end

    if (ocw3_wr) begin
      if (din[OCW3_ESMM]) smm_nxt    = din[OCW3_SMM];
      if (din[OCW3_P])    poll_nxt   = 1'b1;
      if (din[OCW3_RR])   rd_isr_nxt = din[OCW3_RIS];
    end
  end

endmodule

// File: rtl/pic_cmd_sequencer.sv
// Write-side command sequencer for the PIC: walks the ICW1..ICW4 init
// sequence, then holds OCW configuration and issues one-cycle command pulses.
module pic_cmd_sequencer
  import pic_pkg::*;
#(
  parameter bit         CASCADE_EN = 1'b1,
  parameter logic [7:0] IMR_INIT   = IMR_INIT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_pulse,
  input  logic       a0,
  input  logic [7:0] din,
  output logic       init_done,
  output logic       ltim,
  output logic       sngl,
  output logic [4:0] vec_base,
  output logic [7:0] cas_cfg,
  output logic       upm,
  output logic       aeoi,
  output logic [1:0] buf_ms,
  output logic       sfnm,
  output logic [7:0] imr,
  output logic       irr_clr,
  output logic       eoi_ns,
  output logic       eoi_sp,
  output logic       rot_en,
  output logic       rot_ns,
  output logic       set_pri,
  output logic [2:0] lvl,
  output logic       smm,
  output logic       poll,
  output logic       rd_isr,
  output logic       proto_err
);

  state_t state;
  logic   ic4;
  logic   icw1_wr;
  logic   cmd_wr;

  logic eoi_ns_nxt, eoi_sp_nxt, rot_ns_nxt, set_pri_nxt, poll_nxt;
  logic rot_en_nxt, smm_nxt, rd_isr_nxt;
  logic [2:0] lvl_nxt;

  assign icw1_wr   = wr_pulse && !a0 && din[ICW1_SEL];
  assign cmd_wr    = wr_pulse && !a0 && (state == ST_READY);
  assign init_done = (state == ST_READY);

  pic_ocw_decode u_ocw_decode (
    .cmd_wr      (cmd_wr),
    .din         (din),
    .rot_en      (rot_en),
    .smm         (smm),
    .rd_isr      (rd_isr),
    .lvl         (lvl),
    .eoi_ns_nxt  (eoi_ns_nxt),
    .eoi_sp_nxt  (eoi_sp_nxt),
    .rot_ns_nxt  (rot_ns_nxt),
    .set_pri_nxt (set_pri_nxt),
    .poll_nxt    (poll_nxt),
    .rot_en_nxt  (rot_en_nxt),
    .smm_nxt     (smm_nxt),
    .rd_isr_nxt  (rd_isr_nxt),
    .lvl_nxt     (lvl_nxt)
  );

  // ICW1 is handled last so it overrides any OCW flag update in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      ic4       <= 1'b0;
      ltim      <= 1'b0;
      sngl      <= 1'b0;
      vec_base  <= 5'd0;
      cas_cfg   <= 8'd0;
      upm       <= 1'b0;
      aeoi      <= 1'b0;
      buf_ms    <= 2'd0;
      sfnm      <= 1'b0;
      imr       <= IMR_INIT;
      irr_clr   <= 1'b0;
      eoi_ns    <= 1'b0;
      eoi_sp    <= 1'b0;
      rot_en    <= 1'b0;
      rot_ns    <= 1'b0;
      set_pri   <= 1'b0;
      lvl       <= 3'd0;
      smm       <= 1'b0;
      poll      <= 1'b0;
      rd_isr    <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      irr_clr   <= 1'b0;
      proto_err <= 1'b0;
      eoi_ns    <= eoi_ns_nxt;
      eoi_sp    <= eoi_sp_nxt;
      rot_ns    <= rot_ns_nxt;
      set_pri   <= set_pri_nxt;
      poll      <= poll_nxt;
      rot_en    <= rot_en_nxt;
      smm       <= smm_nxt;
      rd_isr    <= rd_isr_nxt;
      lvl       <= lvl_nxt;

      if (icw1_wr) begin
        ltim    <= din[ICW1_LTIM];
        sngl    <= din[ICW1_SNGL];
        ic4     <= din[ICW1_IC4];
        imr     <= IMR_INIT;
        smm     <= 1'b0;
        rd_isr  <= 1'b0;
        rot_en  <= 1'b0;
        lvl     <= 3'd7;
        irr_clr <= 1'b1;
        if (!din[ICW1_IC4]) begin
          upm    <= 1'b0;
          aeoi   <= 1'b0;
          buf_ms <= 2'd0;
          sfnm   <= 1'b0;
        end
        state <= ST_WAIT_ICW2;
      end else if (wr_pulse) begin
        case (state)
          ST_WAIT_ICW2: begin
            if (a0) begin
              vec_base <= din[7:3];
              if (!sngl && CASCADE_EN) state <= ST_WAIT_ICW3;
              else if (ic4)            state <= ST_WAIT_ICW4;
              else                     state <= ST_READY;
            end else begin
              proto_err <= 1'b1;
            end
          end
          ST_WAIT_ICW3: begin
            if (a0) begin
              cas_cfg <= din;
              state   <= ic4 ? ST_WAIT_ICW4 : ST_READY;
            end else begin
              proto_err <= 1'b1;
            end
          end
          ST_WAIT_ICW4: begin
            if (a0) begin
              upm    <= din[0];
              aeoi   <= din[1];
              buf_ms <= din[3:2];
              sfnm   <= din[4];
              state  <= ST_READY;
            end else begin
              proto_err <= 1'b1;
            end
          end
          ST_READY: begin
            if (a0) imr <= din;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pic_cmd_sequencer.sv
// Directed bench for pic_cmd_sequencer: init sequences, OCW decode,
// protocol-error handling and mid-sequence reset.
module tb_pic_cmd_sequencer;
  import pic_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_pulse;
  logic       a0;
  logic [7:0] din;
  logic       init_done, ltim, sngl, upm, aeoi, sfnm, irr_clr;
  logic       eoi_ns, eoi_sp, rot_en, rot_ns, set_pri, smm, poll, rd_isr, proto_err;
  logic [4:0] vec_base;
  logic [7:0] cas_cfg, imr;
  logic [1:0] buf_ms;
  logic [2:0] lvl;

  int checks = 0;
  int errors = 0;

  pic_cmd_sequencer #(.CASCADE_EN(1'b1), .IMR_INIT(8'h00)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_pulse  (wr_pulse),
    .a0        (a0),
    .din       (din),
    .init_done (init_done),
    .ltim      (ltim),
    .sngl      (sngl),
    .vec_base  (vec_base),
    .cas_cfg   (cas_cfg),
    .upm       (upm),
    .aeoi      (aeoi),
    .buf_ms    (buf_ms),
    .sfnm      (sfnm),
    .imr       (imr),
    .irr_clr   (irr_clr),
    .eoi_ns    (eoi_ns),
    .eoi_sp    (eoi_sp),
    .rot_en    (rot_en),
    .rot_ns    (rot_ns),
    .set_pri   (set_pri),
    .lvl       (lvl),
    .smm       (smm),
    .poll      (poll),
    .rd_isr    (rd_isr),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  // One-cycle write; returns at the following negedge, where pulses are visible.
  task automatic applyStimulus(input logic addr, input logic [7:0] data);
    @(negedge clk);
    wr_pulse = 1'b1;
    a0       = addr;
    din      = data;
    @(negedge clk);
    wr_pulse = 1'b0;
    a0       = 1'b0;
    din      = 8'h00;
  endtask

  task automatic idleCycle();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    reset    = 1'b1;
    wr_pulse = 1'b0;
    a0       = 1'b0;
    din      = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_init_done", {7'd0, init_done}, 8'h00);
    checkOutput("rst_imr", imr, 8'h00);
    checkOutput("rst_lvl", {5'd0, lvl}, 8'h00);
    checkOutput("rst_state", {5'd0, dut.state}, {5'd0, ST_IDLE});
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] single-mode init with ICW4");
    applyStimulus(1'b0, 8'h13);
    checkOutput("icw1_irr_clr", {7'd0, irr_clr}, 8'h01);
    checkOutput("icw1_state", {5'd0, dut.state}, {5'd0, ST_WAIT_ICW2});
    checkOutput("icw1_lvl", {5'd0, lvl}, 8'h07);
    checkOutput("icw1_sngl", {7'd0, sngl}, 8'h01);
    applyStimulus(1'b1, 8'h40);
    checkOutput("icw2_vec_base", {3'd0, vec_base}, 8'h08);
    checkOutput("icw2_irr_clr_low", {7'd0, irr_clr}, 8'h00);
    checkOutput("icw2_state_skip3", {5'd0, dut.state}, {5'd0, ST_WAIT_ICW4});
    checkOutput("icw2_init_done", {7'd0, init_done}, 8'h00);
    applyStimulus(1'b1, 8'h03);
    checkOutput("icw4_upm", {7'd0, upm}, 8'h01);
    checkOutput("icw4_aeoi", {7'd0, aeoi}, 8'h01);
    checkOutput("icw4_init_done", {7'd0, init_done}, 8'h01);

    $display("[TB] cascade init through ICW3");
    applyStimulus(1'b0, 8'h19);
    checkOutput("c_icw1_ltim", {7'd0, ltim}, 8'h01);
    checkOutput("c_icw1_upm_kept", {7'd0, upm}, 8'h01);
    applyStimulus(1'b1, 8'h20);
    checkOutput("c_icw2_vec_base", {3'd0, vec_base}, 8'h04);
    checkOutput("c_icw2_state", {5'd0, dut.state}, {5'd0, ST_WAIT_ICW3});
    applyStimulus(1'b1, 8'h04);
    checkOutput("c_icw3_cas_cfg", cas_cfg, 8'h04);
    checkOutput("c_icw3_state", {5'd0, dut.state}, {5'd0, ST_WAIT_ICW4});
    applyStimulus(1'b1, 8'h01);
    checkOutput("c_icw4_upm", {7'd0, upm}, 8'h01);
    checkOutput("c_icw4_aeoi", {7'd0, aeoi}, 8'h00);
    checkOutput("c_icw4_init_done", {7'd0, init_done}, 8'h01);

    $display("[TB] OCW1 then re-init without ICW4");
    applyStimulus(1'b1, 8'hA5);
    checkOutput("ocw1_imr", imr, 8'hA5);
    applyStimulus(1'b0, 8'h12);
    checkOutput("reinit_imr", imr, 8'h00);
    checkOutput("reinit_upm", {7'd0, upm}, 8'h00);
    checkOutput("reinit_aeoi", {7'd0, aeoi}, 8'h00);
    checkOutput("reinit_init_done", {7'd0, init_done}, 8'h00);
    applyStimulus(1'b1, 8'h48);
    checkOutput("reinit_vec_base", {3'd0, vec_base}, 8'h09);
    checkOutput("reinit_ready", {7'd0, init_done}, 8'h01);

    $display("[TB] OCW2 commands");
    applyStimulus(1'b0, 8'h63);
    checkOutput("sp_eoi_eoi_sp", {7'd0, eoi_sp}, 8'h01);
    checkOutput("sp_eoi_eoi_ns", {7'd0, eoi_ns}, 8'h00);
    checkOutput("sp_eoi_lvl", {5'd0, lvl}, 8'h03);
    idleCycle();
    checkOutput("sp_eoi_pulse_end", {7'd0, eoi_sp}, 8'h00);
    applyStimulus(1'b0, 8'hA0);
    checkOutput("rot_ns_eoi_ns", {7'd0, eoi_ns}, 8'h01);
    checkOutput("rot_ns_rot_ns", {7'd0, rot_ns}, 8'h01);
    checkOutput("rot_ns_lvl_kept", {5'd0, lvl}, 8'h03);
    applyStimulus(1'b0, 8'hC5);
    checkOutput("set_pri_pulse", {7'd0, set_pri}, 8'h01);
    checkOutput("set_pri_lvl", {5'd0, lvl}, 8'h05);
    checkOutput("set_pri_no_eoi", {7'd0, eoi_ns}, 8'h00);
    applyStimulus(1'b0, 8'h80);
    checkOutput("rot_set_rot_en", {7'd0, rot_en}, 8'h01);
    checkOutput("rot_set_no_pulse", {6'd0, set_pri, rot_ns}, 8'h00);

    $display("[TB] OCW3 commands");
    applyStimulus(1'b0, 8'h6B);
    checkOutput("ocw3_smm", {7'd0, smm}, 8'h01);
    checkOutput("ocw3_rd_isr", {7'd0, rd_isr}, 8'h01);
    checkOutput("ocw3_no_poll", {7'd0, poll}, 8'h00);
    applyStimulus(1'b0, 8'h0C);
    checkOutput("ocw3_poll", {7'd0, poll}, 8'h01);
    checkOutput("ocw3_rd_isr_kept", {7'd0, rd_isr}, 8'h01);
    checkOutput("ocw3_smm_kept", {7'd0, smm}, 8'h01);

    $display("[TB] protocol error, mid-init restart, reset");
    applyStimulus(1'b0, 8'h13);
    checkOutput("p_icw1_smm_clr", {7'd0, smm}, 8'h00);
    checkOutput("p_icw1_rot_en_clr", {7'd0, rot_en}, 8'h00);
    checkOutput("p_icw1_rd_isr_clr", {7'd0, rd_isr}, 8'h00);
    applyStimulus(1'b0, 8'h20);
    checkOutput("p_proto_err", {7'd0, proto_err}, 8'h01);
    checkOutput("p_state_held", {5'd0, dut.state}, {5'd0, ST_WAIT_ICW2});
    applyStimulus(1'b0, 8'h17);
    checkOutput("p_restart_irr_clr", {7'd0, irr_clr}, 8'h01);
    checkOutput("p_restart_no_err", {7'd0, proto_err}, 8'h00);
    checkOutput("p_restart_state", {5'd0, dut.state}, {5'd0, ST_WAIT_ICW2});
    applyStimulus(1'b1, 8'h40);
    checkOutput("p_wait_icw4", {5'd0, dut.state}, {5'd0, ST_WAIT_ICW4});
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_state", {5'd0, dut.state}, {5'd0, ST_IDLE});
    checkOutput("mid_rst_vec_base", {3'd0, vec_base}, 8'h00);
    checkOutput("mid_rst_sngl", {7'd0, sngl}, 8'h00);
    checkOutput("mid_rst_lvl", {5'd0, lvl}, 8'h00);
    checkOutput("mid_rst_imr", imr, 8'h00);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] IDLE ignores non-ICW1 writes");
    applyStimulus(1'b1, 8'hFF);
    checkOutput("idle_imr", imr, 8'h00);
    checkOutput("idle_no_err", {7'd0, proto_err}, 8'h00);
    applyStimulus(1'b0, 8'h20);
    checkOutput("idle_ocw_no_err", {7'd0, proto_err}, 8'h00);
    checkOutput("idle_ocw_no_eoi", {7'd0, eoi_ns}, 8'h00);
    checkOutput("idle_state", {5'd0, dut.state}, {5'd0, ST_IDLE});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pic_cmd_sequencer.md
Name: pic_cmd_sequencer

Overview:
Write-side command sequencer for the 8259A-style PIC. It consumes qualified CPU write strobes with A0 and the data byte, and walks the ICW1→ICW2→(ICW3)→(ICW4) initialization sequence. Once initialized, it decodes OCW1/OCW2/OCW3 and drives registered configuration fields and single-cycle command pulses. Sits between the read/write control logic and the IMR/IRR/priority-resolver/cascade blocks; it is the only writer of their configuration.

Parameters:
CASCADE_EN, 1, 0 forces the ICW3 step to be skipped regardless of SNGL.
IMR_INIT, 8'h00, value loaded into imr on reset and on every ICW1.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
wr_pulse  in  1  one-cycle write strobe (already CS-qualified, synchronized)
a0  in  1  address bit A0 sampled with wr_pulse
din  in  8  write data sampled with wr_pulse
init_done  out  1  high in READY state
ltim  out  1  ICW1.D3: 1 = level triggered
sngl  out  1  ICW1.D1
vec_base  out  5  ICW2.D7:D3 (T7..T3)
cas_cfg  out  8  ICW3 byte (master: slave map; slave: ID in [2:0])
upm  out  1  ICW4.D0
aeoi  out  1  ICW4.D1
buf_ms  out  2  ICW4.D3:D2
sfnm  out  1  ICW4.D4
imr  out  8  OCW1 mask
irr_clr  out  1  one-cycle pulse on ICW1
eoi_ns  out  1  non-specific EOI pulse
eoi_sp  out  1  specific EOI pulse
rot_en  out  1  rotate-on-AEOI mode flag
rot_ns  out  1  rotate-on-non-specific-EOI pulse
set_pri  out  1  set-priority pulse (lowest = lvl)
lvl  out  3  OCW2.D2:D0 level, valid with eoi_sp/rot_ns-specific/set_pri
smm  out  1  special mask mode flag
poll  out  1  poll-command pulse
rd_isr  out  1  read-select: 0 = IRR, 1 = ISR
proto_err  out  1  pulse: unexpected A0=0 non-ICW1 write during init

Behaviour:
- States: IDLE, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY. Reset → IDLE. All outputs are 0 except imr = IMR_INIT. Pulses are registered and one cycle wide, asserted in the cycle after wr_pulse.
- ICW1 detect (a0=0 & din[4]=1) in ANY state, including mid-init: latch ltim=din[3], sngl=din[1], and ic4 (internal) = din[0]. Set imr=IMR_INIT, smm=0, rd_isr=0, rot_en=0, lvl=3'd7. If din[0]=0, clear upm/aeoi/buf_ms/sfnm. Pulse irr_clr. Go to WAIT_ICW2.
- WAIT_ICW2: a0=1 write → vec_base=din[7:3]. Next state: WAIT_ICW3 if (sngl=0 & CASCADE_EN); else WAIT_ICW4 if ic4; else READY.
- WAIT_ICW3: a0=1 → cas_cfg=din. Next: WAIT_ICW4 if ic4, else READY.
- WAIT_ICW4: a0=1 → upm=din[0], aeoi=din[1], buf_ms=din[3:2], sfnm=din[4]. Go to READY.
- In WAIT_* states, an a0=0 write with din[4]=0 is ignored, proto_err pulses, and the state is held.
- READY, a0=1: imr=din (OCW1).
- READY, a0=0, din[4:3]=00 (OCW2), decoded on din[7:5]:
  - 001: eoi_ns.
  - 011: eoi_sp, lvl=din[2:0].
  - 101: eoi_ns + rot_ns.
  - 100: rot_en=1.
  - 000: rot_en=0.
  - 111: eoi_sp + rot_ns, lvl=din[2:0].
  - 110: set_pri, lvl=din[2:0].
  - 010: no-op.
- READY, a0=0, din[4:3]=01 (OCW3):
  - if din[6]=1, smm=din[5];
  - if din[2]=1, pulse poll;
  - if din[1]=1, rd_isr=din[0].
- IDLE: a0=1 writes and OCW-form writes are ignored without proto_err.
- wr_pulse in consecutive cycles: each is processed in order; no back-pressure.
- Reset asserted mid-sequence: immediate return to IDLE, all outputs forced to reset values, and any pending pulse dropped.

Decomposition:
- Shared package pic_pkg: state enum; ICW1/OCW2/OCW3 bit-position constants; OCW2 R/SL/EOI code constants; IMR_INIT default.
- One sub-module, pic_ocw_decode: combinational OCW2/OCW3 field decode producing next pulse/flag values. The FSM and registers remain in the top.

Test Plan:
- Reset, then ICW1=8'h13 (sngl, ic4), ICW2 a0=1 8'h40, ICW4 a0=1 8'h03 → ICW3 skipped; vec_base=5'h08, upm=1, aeoi=1, init_done=1 after the 3rd write; irr_clr pulsed once.
- ICW1=8'h19 (cascade, ltim, ic4=1), ICW2 8'h20, ICW3 8'h04, ICW4 8'h01 → cas_cfg=8'h04, ltim=1, state passes through WAIT_ICW3.
- In READY: OCW1 a0=1 8'hA5 → imr=8'hA5. Then ICW1=8'h12 → imr=8'h00, upm/aeoi cleared, init_done=0.
- OCW2 8'h63 → eoi_sp, lvl=3; 8'hA0 → eoi_ns + rot_ns; 8'hC5 → set_pri, lvl=5; 8'h80 → rot_en=1.
- OCW3 8'h6B → smm=1, rd_isr=1; OCW3 8'h0C → poll pulse only, rd_isr unchanged.
- During WAIT_ICW2, write a0=0 8'h20 → proto_err pulse, state held. Then ICW1 mid-init restarts to WAIT_ICW2. Assert reset mid-WAIT_ICW4 → all outputs at reset values, state IDLE.
